sevenseg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-cathode/anode seven-segment display. It holds a packed hex value, decodes one digit at a time through a shared hex-to-segment decoder (all seven segments, 0-F), and scans digit enables round-robin with an inter-digit blanking guard. New values are double-buffered and applied only at frame boundaries to avoid tearing. It sits between the datapath (value producer) and the board display pins.

---
 rtl/sevenseg_pkg.sv | 49 ++++
 rtl/sevenseg_scan_driver_if.sv | 24 ++
 rtl/hex_to_7seg.sv | 9 +
 rtl/sevenseg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment bit
// positions, the 0-F glyph table and the scan FSM state type.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;

    // Bit position of each segment inside a seg_t (a = bit 0 ... g = bit 6).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam seg_t M_A = seg_t'(1 << SEG_A);
    localparam seg_t M_B = seg_t'(1 << SEG_B);
    localparam seg_t M_C = seg_t'(1 << SEG_C);
    localparam seg_t M_D = seg_t'(1 << SEG_D);
    localparam seg_t M_E = seg_t'(1 << SEG_E);
    localparam seg_t M_F = seg_t'(1 << SEG_F);
    localparam seg_t M_G = seg_t'(1 << SEG_G);

    // Standard hex glyphs, logical level (1 = segment lit).
    localparam seg_t GLYPH_TABLE [16] = '{
        M_A | M_B | M_C | M_D | M_E | M_F,        // 0
        M_B | M_C,                                // 1
        M_A | M_B | M_D | M_E | M_G,              // 2
        M_A | M_B | M_C | M_D | M_G,              // 3
        M_B | M_C | M_F | M_G,                    // 4
        M_A | M_C | M_D | M_F | M_G,              // 5
        M_A | M_C | M_D | M_E | M_F | M_G,        // 6
        M_A | M_B | M_C,                          // 7
        M_A | M_B | M_C | M_D | M_E | M_F | M_G,  // 8
        M_A | M_B | M_C | M_D | M_F | M_G,        // 9
        M_A | M_B | M_C | M_E | M_F | M_G,        // A
        M_C | M_D | M_E | M_F | M_G,              // b
        M_A | M_D | M_E | M_F,                    // C
        M_B | M_C | M_D | M_E | M_G,              // d
        M_A | M_D | M_E | M_F | M_G,              // E
        M_A | M_E | M_F | M_G                     // F
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Bundle between the value producer (master) and the scan driver (slave);
// the slave side also carries the display pin outputs.
interface sevenseg_scan_driver_if
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank_mask;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_done;

    modport master (
        output load, value, blank_mask,
        input  seg, digit_en, frame_done
    );

    modport slave (
        input  load, value, blank_mask,
        output seg, digit_en, frame_done
    );
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit to seven-segment decoder (logical levels).
module hex_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);
    assign seg_o = GLYPH_TABLE[nibble_i];
endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a blanking guard
// before each digit and frame-boundary double buffering of the value.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant non-zero nibble (digit 0 is always shown).
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int GUARD      = 2,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    sevenseg_scan_driver_if.slave bus
);
    localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // With no guard the BLANK state is never visited.
    localparam scan_state_t      SLOT_START = (GUARD > 0) ? BLANK : SHOW;
    // Pin-level "off" patterns; XOR with these applies the polarity.
    localparam seg_t                  SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wrap_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    frame_done_q;

    logic [3:0]              nib [NUM_DIGITS];
    logic [3:0]              nib_sel;
    seg_t                    glyph;
    logic [NUM_DIGITS-1:0]   blank_vec;

    // Slot timing: guard count, then lit count, then advance digit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = SLOT_START;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SLOT_START;
        endcase
    end

    // Double buffer: active picks up the old shadow at a wrap, before any
    // load on that same edge refills the shadow and re-arms pending.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (wrap_d && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end
    end

    // Split the next active value into nibbles for the shared decoder.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = active_d[4*gi +: 4];
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i (i>0) is a leading zero when every nibble from i upward is 0.
    logic [NUM_DIGITS-1:0] lz_blank;
    assign lz_blank[0] = 1'b0;
    generate
        for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lz_blank[gi] = (active_d[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate
    assign blank_vec = bus.blank_mask | lz_blank;
`else
    assign blank_vec = bus.blank_mask;
`endif

    assign nib_sel = nib[idx_d];

    hex_to_7seg u_dec (
        .nibble_i (nib_sel),
        .seg_o    (glyph)
    );

    // Pin values for the next cycle, computed from the next state so the
    // registered outputs change on the same edge as state/idx.
    always_comb begin
        seg_d      = SEG_OFF;
        digit_en_d = EN_OFF;
        if (state_d == SHOW) begin
            digit_en_d = (NUM_DIGITS'(1) << idx_d) ^ EN_OFF;
            if (!blank_vec[idx_d]) begin
                seg_d = glyph ^ SEG_OFF;
            end
        end
    end

    // State, buffers and registered pin outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= SLOT_START;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            digit_en_q   <= EN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= wrap_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: two instances (4 digits / 3-cycle slots /
// 1 guard / active-high, and 3 digits / 2-cycle slots / no guard / active-low)
// checked every cycle against a frame-arithmetic reference model.
module tb_sevenseg_scan_driver;
    localparam int ND [2] = '{4, 3};
    localparam int SD [2] = '{3, 2};
    localparam int GD [2] = '{1, 0};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sevenseg_scan_driver_if #(.NUM_DIGITS(4)) if0 ();
    sevenseg_scan_driver_if #(.NUM_DIGITS(3)) if1 ();

    sevenseg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(3), .GUARD(1), .ACTIVE_LOW(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    sevenseg_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(2), .GUARD(0), .ACTIVE_LOW(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset release plus the frame buffers.
    int          n_m    [2];
    logic [15:0] sh_m   [2];
    logic [15:0] act_m  [2];
    logic        pend_m [2];
    logic [3:0]  m0_cur;
    logic [2:0]  m1_cur;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Glyphs written as the lit segment letters.
    function automatic logic [6:0] glyph(input logic [3:0] h);
        string s;
        logic [6:0] g;
        g = '0;
        case (h)
            4'h0: s = "abcdef";   4'h1: s = "bc";
            4'h2: s = "abdeg";    4'h3: s = "abcdg";
            4'h4: s = "bcfg";     4'h5: s = "acdfg";
            4'h6: s = "acdefg";   4'h7: s = "abc";
            4'h8: s = "abcdefg";  4'h9: s = "abcdfg";
            4'hA: s = "abcefg";   4'hB: s = "cdefg";
            4'hC: s = "adef";     4'hD: s = "bcdeg";
            4'hE: s = "adefg";    default: s = "aefg";
        endcase
        for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b1;
        return g;
    endfunction

    function automatic void model_step(input int c, input logic rst, input logic ld, input logic [15:0] v);
        if (rst) begin
            n_m[c] = 0; sh_m[c] = '0; act_m[c] = '0; pend_m[c] = 1'b0;
        end else begin
            n_m[c]++;
            if (n_m[c] % (ND[c] * (GD[c] + SD[c])) == 0 && pend_m[c]) begin
                act_m[c]  = sh_m[c];
                pend_m[c] = 1'b0;
            end
            if (ld) begin
                sh_m[c]   = v;
                pend_m[c] = 1'b1;
            end
        end
    endfunction

    // Expected logical outputs after the current edge.
    function automatic void expect_out(input int c, input logic [3:0] mask,
                                       output logic [6:0] seg, output logic [3:0] en, output logic fd);
        int per, q, d, r;
        seg = '0; en = '0; fd = 1'b0;
        if (n_m[c] == 0) return;
        per = GD[c] + SD[c];
        q   = n_m[c] % (ND[c] * per);
        d   = q / per;
        r   = q % per;
        fd  = (q == 0);
        if (r < GD[c]) return;
        en = 4'(1 << d);
        if (mask[d]) return;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int k = 0; k < ND[c]; k++) if (act_m[c][4*k +: 4] != 4'h0) msd = k;
            if (d > msd) return;
        end
`endif
        seg = glyph(act_m[c][4*d +: 4]);
    endfunction

    task automatic tick(input logic rst, input logic ld, input logic [15:0] v);
        logic [6:0] es, es_pin;
        logic [3:0] ee;
        logic [2:0] ee_pin;
        logic       ef;
        @(negedge clock);
        reset          = rst;
        if0.load       = ld;
        if0.value      = v;
        if0.blank_mask = m0_cur;
        if1.load       = ld;
        if1.value      = v[11:0];
        if1.blank_mask = m1_cur;
        @(posedge clock);
        #1;
        if (rst) $display("reset t=%0t", $time);
        else if (ld) $display("load value=%04h n0=%0d n1=%0d", v, n_m[0] + 1, n_m[1] + 1);
        model_step(0, rst, ld, v);
        model_step(1, rst, ld, {4'h0, v[11:0]});
        expect_out(0, m0_cur, es, ee, ef);
        check_eq("c0_seg", 32'(if0.seg), 32'(es));
        check_eq("c0_digit_en", 32'(if0.digit_en), 32'(ee));
        check_eq("c0_frame_done", 32'(if0.frame_done), 32'(ef));
        expect_out(1, {1'b0, m1_cur}, es, ee, ef);
        es_pin = ~es;
        ee_pin = ~ee[2:0];
        check_eq("c1_seg", 32'(if1.seg), 32'(es_pin));
        check_eq("c1_digit_en", 32'(if1.digit_en), 32'(ee_pin));
        check_eq("c1_frame_done", 32'(if1.frame_done), 32'(ef));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) tick(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        m0_cur = '0; m1_cur = '0;
        if0.load = 1'b0; if0.value = '0; if0.blank_mask = '0;
        if1.load = 1'b0; if1.value = '0; if1.blank_mask = '0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0);

        // Basic scan with a first value, shown only after the first wrap.
        tick(1'b0, 1'b1, 16'h1234);
        run(40);

        // Glyph sweep: one value per frame.
        for (int h = 0; h < 16; h++) begin
            tick(1'b0, 1'b1, 16'(h));
            run(15);
        end

        // Mid-frame load.
        for (int i = 0; i < 16 && ((n_m[0] + 1) % 16) != 5; i++) run(1);
        tick(1'b0, 1'b1, 16'hAAAA);
        run(30);

        // Load on the wrap edge itself.
        for (int i = 0; i < 16 && ((n_m[0] + 1) % 16) != 0; i++) run(1);
        tick(1'b0, 1'b1, 16'h5555);
        run(40);

        // Live blank mask on one digit.
        m0_cur = 4'b0100; m1_cur = 3'b100;
        run(32);
        m0_cur = '0; m1_cur = '0;

        // Reset while digit 2 is lit.
        tick(1'b0, 1'b1, 16'h9876);
        run(20);
        for (int i = 0; i < 32; i++) begin
            if ((((n_m[0] + 1) % 16) / 4) == 2 && (((n_m[0] + 1) % 16) % 4) >= 1) break;
            run(1);
        end
        tick(1'b1, 1'b0, 16'h0);
        run(20);

        // Leading-zero style values.
        tick(1'b0, 1'b1, 16'h0050);
        run(40);
        tick(1'b0, 1'b1, 16'h0000);
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            m0_cur = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            m1_cur = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'h0;
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
